// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_RSV  = 2'd3
  } lat_class_e;

  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_REG_W    = 4;
  localparam int unsigned DEF_CNT_W    = 3;
  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned DEF_MUL_LAT  = 3;

  typedef logic [DEF_REG_W-1:0] reg_addr_t;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side issue bundle and scoreboard status; SCOREBOARD_STATS_EN adds stall statistics.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned REG_W    = DEF_REG_W
);

  logic             issue_valid;
  logic [REG_W-1:0] src_a;
  logic             src_a_used;
  logic [REG_W-1:0] src_b;
  logic             src_b_used;
  logic [REG_W-1:0] dest;
  logic             dest_wr;
  lat_class_e       lat_class;
  logic             flush;

  logic                stall;
  logic [NUM_REGS-1:0] pending;
  logic                busy;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] raw_events;

  modport master (
    output issue_valid, src_a, src_a_used, src_b, src_b_used,
           dest, dest_wr, lat_class, flush,
    input  stall, pending, busy, stall_cycles, raw_events
  );

  modport slave (
    input  issue_valid, src_a, src_a_used, src_b, src_b_used,
           dest, dest_wr, lat_class, flush,
    output stall, pending, busy, stall_cycles, raw_events
  );
`else
  modport master (
    output issue_valid, src_a, src_a_used, src_b, src_b_used,
           dest, dest_wr, lat_class, flush,
    input  stall, pending, busy
  );

  modport slave (
    input  issue_valid, src_a, src_a_used, src_b, src_b_used,
           dest, dest_wr, lat_class, flush,
    output stall, pending, busy
  );
`endif

endinterface

// File: rtl/hazard_scoreboard_reg_counter.sv
// Per-register saturating countdown of bubbles still owed before forwarding can serve it.
module sb_reg_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);

  // A new write to this register overrides the countdown of the older one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign nz = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: stalls RAW/WAW hazards on long-latency writes.
// Optional SCOREBOARD_STATS_EN adds stall_cycles / raw_events counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned REG_W    = DEF_REG_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
  parameter int unsigned MUL_LAT  = DEF_MUL_LAT
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  sb
);

  generate
    if (((1 << CNT_W) - 1) < max_lat(LOAD_LAT, MUL_LAT)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for LOAD_LAT/MUL_LAT");
    end
    if ((1 << REG_W) < NUM_REGS) begin : g_bad_reg_w
      $error("REG_W cannot address NUM_REGS registers");
    end
  endgenerate

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] ld;
  logic [CNT_W-1:0]    new_lat;
  logic                raw_a;
  logic                raw_b;
  logic                waw;
  logic                stall;
  logic                accept;

  always_comb begin
    new_lat = '0;
    case (sb.lat_class)
      LAT_LOAD: new_lat = CNT_W'(LOAD_LAT);
      LAT_MUL:  new_lat = CNT_W'(MUL_LAT);
      default:  new_lat = '0;
    endcase
  end

  // Hazard checks see the pre-update counters, so LOAD r3,[r3] is judged on the old r3.
  always_comb begin
    raw_a  = sb.src_a_used & (cnt[sb.src_a] != '0);
    raw_b  = sb.src_b_used & (cnt[sb.src_b] != '0);
    waw    = sb.dest_wr & (cnt[sb.dest] > new_lat);
    stall  = sb.issue_valid & ~sb.flush & (raw_a | raw_b | waw);
    accept = sb.issue_valid & ~sb.flush & ~stall;
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      assign ld[i] = accept & sb.dest_wr & (sb.dest == REG_W'(i));

      sb_reg_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld[i]),
        .ld_val (new_lat),
        .cnt    (cnt[i]),
        .nz     (nz[i])
      );
    end
  endgenerate

  assign sb.stall   = stall;
  assign sb.pending = nz;
  assign sb.busy    = |nz;

`ifdef SCOREBOARD_STATS_EN
  logic        stall_q;
  logic [31:0] stall_cycles;
  logic [15:0] raw_events;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q      <= 1'b0;
      stall_cycles <= '0;
      raw_events   <= '0;
    end else begin
      stall_q <= stall;
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (stall && !stall_q) begin
        raw_events <= raw_events + 16'd1;
      end
    end
  end

  assign sb.stall_cycles = stall_cycles;
  assign sb.raw_events   = raw_events;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed cases plus randomized issue stream.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NR       = 16;
  localparam int LOAD_L   = 1;
  localparam int MUL_L    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_scoreboard_if #(.NUM_REGS(NR), .REG_W(4)) sb_if ();

  hazard_scoreboard #(
    .NUM_REGS (NR),
    .REG_W    (4),
    .CNT_W    (3),
    .LOAD_LAT (LOAD_L),
    .MUL_LAT  (MUL_L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int a; bit au; int b; bit bu; int d; bit dw; int lc; bit fl;
  } instr_t;

  typedef struct {
    logic          stall;
    logic [NR-1:0] pending;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: absolute cycle at which each register becomes forwardable.
  int now = 0;
  int ready_at [NR];
  int stall_cyc = 0;
  int raw_ev    = 0;
  bit prev_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input int lc);
    if (lc == 1) return LOAD_L;
    if (lc == 2) return MUL_L;
    return 0;
  endfunction

  function automatic bit model_stall(input instr_t in);
    bit ra, rb, ww;
    ra = in.au && (ready_at[in.a] > now);
    rb = in.bu && (ready_at[in.b] > now);
    ww = in.dw && ((ready_at[in.d] - now) > lat_of(in.lc));
    return in.v && !in.fl && (ra || rb || ww);
  endfunction

  function automatic instr_t mk(input bit v, input int a, input bit au, input int b, input bit bu,
                                input int d, input bit dw, input int lc, input bit fl);
    instr_t t;
    t.v = v; t.a = a; t.au = au; t.b = b; t.bu = bu; t.d = d; t.dw = dw; t.lc = lc; t.fl = fl;
    return t;
  endfunction

  function automatic instr_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Enters and leaves at posedge+1; one pipeline cycle per call.
  task automatic step(input instr_t in, output bit dut_stall);
    exp_t e;
    sb_if.issue_valid = in.v;
    sb_if.src_a       = 4'(in.a);
    sb_if.src_a_used  = in.au;
    sb_if.src_b       = 4'(in.b);
    sb_if.src_b_used  = in.bu;
    sb_if.dest        = 4'(in.d);
    sb_if.dest_wr     = in.dw;
    sb_if.lat_class   = lat_class_e'(2'(in.lc));
    sb_if.flush       = in.fl;
    e.stall = model_stall(in);
    for (int r = 0; r < NR; r++) e.pending[r] = (ready_at[r] > now);
    e.busy = |e.pending;
    exp_q.push_back(e);
    #1 dut_stall = sb_if.stall;
    @(posedge clk);
    if (e.stall) stall_cyc++;
    if (e.stall && !prev_stall) raw_ev++;
    prev_stall = e.stall;
    if (in.v && !in.fl && !e.stall && in.dw) ready_at[in.d] = now + 1 + lat_of(in.lc);
    now++;
    #1;
  endtask

  task automatic until_accept(input instr_t in, output int stalls);
    bit st;
    bit done;
    stalls = 0;
    done   = 0;
    for (int k = 0; k < 12 && !done; k++) begin
      step(in, st);
      if (st) stalls++;
      else done = 1;
    end
    if (!done) check("accept_timeout", 1, 0);
  endtask

  task automatic drain(input int n);
    bit st;
    for (int k = 0; k < n; k++) step(idle(), st);
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int r = 0; r < NR; r++) ready_at[r] = 0;
    stall_cyc  = 0;
    raw_ev     = 0;
    prev_stall = 0;
  endtask

  // Monitor: compares each presented cycle against the queued expectation.
  exp_t mon_e;
  int   run = 0;
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("stall",   sb_if.stall,   mon_e.stall);
      check("pending", sb_if.pending, mon_e.pending);
      check("busy",    sb_if.busy,    mon_e.busy);
      run = sb_if.stall ? run + 1 : 0;
      if (run > MUL_L) check("stall_run_bound", run, MUL_L);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit     st;
    int     n;
    instr_t cur;
    bit     held;

    void'(idle());
    sb_if.issue_valid = 0; sb_if.src_a = '0; sb_if.src_a_used = 0;
    sb_if.src_b = '0; sb_if.src_b_used = 0; sb_if.dest = '0; sb_if.dest_wr = 0;
    sb_if.lat_class = LAT_ALU; sb_if.flush = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_stall",   sb_if.stall,   0);
    check("rst_pending", sb_if.pending, 0);
    check("rst_busy",    sb_if.busy,    0);

    // LOAD r5 ; ADD r1,r5,r2
    step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0), st);
    until_accept(mk(1, 5, 1, 2, 1, 1, 1, 0, 0), n);
    check("load_raw_stalls", n, 1);
    drain(4);

    // MUL r4 ; SUB r6,r4,r4
    step(mk(1, 0, 0, 0, 0, 4, 1, 2, 0), st);
    until_accept(mk(1, 4, 1, 4, 1, 6, 1, 0, 0), n);
    check("mul_raw_stalls", n, 3);
    drain(4);

    // LOAD r7 ; ADDI r8,r9,#imm
    step(mk(1, 0, 0, 0, 0, 7, 1, 1, 0), st);
    until_accept(mk(1, 9, 1, 7, 0, 8, 1, 0, 0), n);
    check("indep_stalls", n, 0);
    drain(4);

    // MUL r2 ; ALU write r2 (WAW)
    step(mk(1, 0, 0, 0, 0, 2, 1, 2, 0), st);
    until_accept(mk(1, 0, 0, 0, 0, 2, 1, 0, 0), n);
    check("waw_stalls", n, 3);
    check("waw_pending2", sb_if.pending[2], 0);
    drain(4);

    // LOAD r3 ; MUL r3 back-to-back
    step(mk(1, 0, 0, 0, 0, 3, 1, 1, 0), st);
    until_accept(mk(1, 0, 0, 0, 0, 3, 1, 2, 0), n);
    check("load_mul_stalls", n, 0);
    check("load_mul_pending3", sb_if.pending[3], 1);
    drain(4);

    // MUL r10 ; flushed dependent ADD never stalls
    step(mk(1, 0, 0, 0, 0, 10, 1, 2, 0), st);
    step(mk(1, 10, 1, 10, 1, 11, 1, 0, 1), st);
    check("flush_no_stall", st, 0);
    drain(4);

    // Randomized stream; a stalled instruction is held until accepted.
    held = 0;
    cur  = idle();
    for (int k = 0; k < 400; k++) begin
      if (!held) begin
        cur = mk(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      end
      step(cur, st);
      held = st;
    end
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", sb_if.stall_cycles, stall_cyc);
    check("raw_events",   sb_if.raw_events,   raw_ev);
`endif
    drain(4);

    // Asynchronous reset while r4 countdown is 2 and a dependent is stalled.
    step(mk(1, 0, 0, 0, 0, 4, 1, 2, 0), st);
    step(mk(1, 4, 1, 4, 1, 6, 1, 0, 0), st);
    check("pre_rst_stall", sb_if.stall, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_stall",   sb_if.stall,   0);
    check("async_rst_pending", sb_if.pending, 0);
    check("async_rst_busy",    sb_if.busy,    0);
`ifdef SCOREBOARD_STATS_EN
    check("async_rst_stall_cycles", sb_if.stall_cycles, 0);
`endif
    model_clear();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    step(mk(1, 4, 1, 4, 1, 6, 1, 0, 0), st);
    check("post_rst_first_issue", st, 0);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
